ram_arbiter: RTL and testbench

Shares the single command port of the unified RAM between two requesters: instruction fetch (I) and load/store data access (D). It grants at most one request per cycle using fixed D-priority with an instruction starvation guard. It returns responses one cycle later, tagged to the requester that won. It also rejects misaligned data accesses without touching memory. It sits between the core's fetch/memory-access sequencing and the RAM instance.

---
 rtl/ram_arbiter_if.sv | 42 ++++
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Request/response bundle between the fetch and load/store requesters, the arbiter
// and the unified RAM command port.
interface ram_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic              d_err;
    logic [31:0]       d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [2:0]        m_size;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_err, d_rdata,
        output m_en, m_we, m_addr, m_size, m_wdata
    );

    // Requester + RAM view
    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_err, d_rdata,
        input  m_en, m_we, m_addr, m_size, m_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the unified RAM: D-priority with an I starvation guard,
// misaligned D rejection, and single-cycle tagged response return.
module ram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);
    localparam int              DATA_W     = 32;
    localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0]      SIZE_WORD  = 3'b010;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_I     = 2'd1,
        OWN_D_OK  = 2'd2,
        OWN_D_ERR = 2'd3
    } owner_t;

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = addr_lo[0];
            3'b010:         bad = (addr_lo != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    logic       d_mis;
    logic       i_win;
    logic       d_win;
    logic [3:0] starve_cnt_p0;
    owner_t     owner_p1;
    owner_t     owner_nxt;
    logic       load_p1;
    logic       load_nxt;

    // ---- Stage 0: combinational arbitration and RAM command ----
    always_comb begin
        d_mis = is_misaligned(bus.d_size, bus.d_addr[1:0]);
        i_win = 1'b0;
        d_win = 1'b0;
        if (reset) begin
            if (bus.i_req && ((starve_cnt_p0 >= STARVE_LIM) || !bus.d_req))
                i_win = 1'b1;
            else if (bus.d_req)
                d_win = 1'b1;
        end
    end

    assign bus.i_gnt = i_win;
    assign bus.d_gnt = d_win;

    // A misaligned D win keeps the slot but never strobes the RAM.
    always_comb begin
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = ADDR_ZERO;
        bus.m_size  = 3'b000;
        bus.m_wdata = '0;
        if (i_win) begin
            bus.m_en   = 1'b1;
            bus.m_addr = bus.i_addr;
            bus.m_size = SIZE_WORD;
        end else if (d_win && !d_mis) begin
            bus.m_en    = 1'b1;
            bus.m_we    = bus.d_we;
            bus.m_addr  = bus.d_addr;
            bus.m_size  = bus.d_size;
            bus.m_wdata = bus.d_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt_p0 <= 4'd0;
        else if (bus.i_req && !i_win) begin
            if (starve_cnt_p0 != 4'hF)
                starve_cnt_p0 <= starve_cnt_p0 + 4'd1;
        end else
            starve_cnt_p0 <= 4'd0;
    end

    // ---- Stage 1: response owner, loaded from this cycle's grant ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_p1 <= OWN_NONE;
            load_p1  <= 1'b0;
        end else begin
            owner_p1 <= owner_nxt;
            load_p1  <= load_nxt;
        end
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        load_nxt  = 1'b0;
        if (i_win) begin
            owner_nxt = OWN_I;
        end else if (d_win) begin
            owner_nxt = d_mis ? OWN_D_ERR : OWN_D_OK;
            load_nxt  = !bus.d_we;
        end
    end

    always_comb begin
        bus.i_rvalid = (owner_p1 == OWN_I);
        bus.d_rvalid = (owner_p1 == OWN_D_OK) || (owner_p1 == OWN_D_ERR);
        bus.d_err    = (owner_p1 == OWN_D_ERR);
        bus.i_rdata  = {DATA_W{1'b0}};
        bus.d_rdata  = {DATA_W{1'b0}};
        if (owner_p1 == OWN_I)
            bus.i_rdata = bus.m_rdata;
        if ((owner_p1 == OWN_D_OK) && load_p1)
            bus.d_rdata = bus.m_rdata;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: byte-addressed RAM model, vector table, response scoreboard.
module tb_ram_arbiter;
    localparam int ADDR_W     = 14;
    localparam int STARVE_MAX = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    ram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Little-endian byte RAM, data returned right-aligned the cycle after m_en.
    logic [7:0] mem [0:(1<<ADDR_W)-1];

    function automatic logic [31:0] ram_read(input int a, input logic [2:0] sz);
        logic [31:0] r;
        case (sz[1:0])
            2'b00:   r = {24'h0, mem[a]};
            2'b01:   r = {16'h0, mem[a+1], mem[a]};
            default: r = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) begin
                mem[int'(bus.m_addr)] <= bus.m_wdata[7:0];
                if (bus.m_size[1:0] != 2'b00)
                    mem[int'(bus.m_addr)+1] <= bus.m_wdata[15:8];
                if (bus.m_size[1:0] == 2'b10) begin
                    mem[int'(bus.m_addr)+2] <= bus.m_wdata[23:16];
                    mem[int'(bus.m_addr)+3] <= bus.m_wdata[31:24];
                end
                bus.m_rdata <= 32'h0;
            end else begin
                bus.m_rdata <= ram_read(int'(bus.m_addr), bus.m_size);
            end
        end
    end

    initial begin
        for (int k = 0; k < (1 << ADDR_W); k++) mem[k] <= 8'h00;
        mem[16'h40] <= 8'hEF;
        mem[16'h41] <= 8'hBE;
        mem[16'h42] <= 8'hAD;
        mem[16'h43] <= 8'hDE;
    end

    typedef struct {
        logic              i_req;
        logic [ADDR_W-1:0] i_addr;
        logic              d_req;
        logic              d_we;
        logic [2:0]        d_size;
        logic [ADDR_W-1:0] d_addr;
        logic [31:0]       d_wdata;
        logic              e_i_gnt;
        logic              e_d_gnt;
        logic              e_m_en;
        logic              e_err;
        logic [31:0]       e_data;
    } vec_t;

    typedef struct {
        logic        is_i;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    vec_t vt[$];
    rsp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic ir, input logic [ADDR_W-1:0] ia, input logic dr, input logic dwe,
                       input logic [2:0] dsz, input logic [ADDR_W-1:0] da, input logic [31:0] dwd,
                       input logic eig, input logic edg, input logic eme, input logic eerr,
                       input logic [31:0] edata);
        vt.push_back('{ir, ia, dr, dwe, dsz, da, dwd, eig, edg, eme, eerr, edata});
    endtask

    task automatic drive(input vec_t v);
        bus.i_req   = v.i_req;
        bus.i_addr  = v.i_addr;
        bus.d_req   = v.d_req;
        bus.d_we    = v.d_we;
        bus.d_size  = v.d_size;
        bus.d_addr  = v.d_addr;
        bus.d_wdata = v.d_wdata;
    endtask

    task automatic drive_idle();
        vec_t v;
        v = '{1'b0, '0, 1'b0, 1'b0, 3'b000, '0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        drive(v);
    endtask

    task automatic check_resp(input string tag);
        rsp_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check({tag, "_i_rvalid"}, 32'(bus.i_rvalid), 32'(r.is_i));
            check({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'(!r.is_i));
            if (r.is_i) begin
                check({tag, "_i_rdata"}, bus.i_rdata, r.data);
            end else begin
                check({tag, "_d_err"}, 32'(bus.d_err), 32'(r.err));
                check({tag, "_d_rdata"}, bus.d_rdata, r.data);
            end
        end else begin
            check({tag, "_i_rvalid_idle"}, 32'(bus.i_rvalid), 32'h0);
            check({tag, "_d_rvalid_idle"}, 32'(bus.d_rvalid), 32'h0);
        end
    endtask

    initial begin
        //  i_req i_addr  d_req we size    d_addr   wdata        igt dgt men err data
        add(1, 14'h040, 0, 0, 3'b010, 14'h000, 32'h0,        1, 0, 1, 0, 32'hDEADBEEF);
        add(0, 14'h000, 0, 0, 3'b010, 14'h000, 32'h0,        0, 0, 0, 0, 32'h0);
        add(0, 14'h000, 1, 1, 3'b010, 14'h100, 32'h12345678, 0, 1, 1, 0, 32'h0);
        add(0, 14'h000, 1, 0, 3'b010, 14'h100, 32'h0,        0, 1, 1, 0, 32'h12345678);
        add(0, 14'h000, 1, 0, 3'b010, 14'h102, 32'h0,        0, 1, 0, 1, 32'h0);
        add(0, 14'h000, 1, 0, 3'b001, 14'h102, 32'h0,        0, 1, 1, 0, 32'h00001234);
        add(0, 14'h000, 1, 0, 3'b101, 14'h103, 32'h0,        0, 1, 0, 1, 32'h0);
        add(0, 14'h000, 1, 0, 3'b011, 14'h100, 32'h0,        0, 1, 0, 1, 32'h0);
        add(1, 14'h040, 1, 1, 3'b000, 14'h105, 32'h000000AB, 0, 1, 1, 0, 32'h0);
        add(1, 14'h040, 1, 0, 3'b100, 14'h105, 32'h0,        0, 1, 1, 0, 32'h000000AB);
        add(1, 14'h040, 1, 0, 3'b010, 14'h100, 32'h0,        0, 1, 1, 0, 32'h12345678);
        add(1, 14'h040, 1, 0, 3'b010, 14'h100, 32'h0,        1, 0, 1, 0, 32'hDEADBEEF);
        add(0, 14'h000, 0, 0, 3'b010, 14'h000, 32'h0,        0, 0, 0, 0, 32'h0);
        for (int c = 0; c < 8; c++) begin
            if (c % 4 == 3)
                add(1, 14'h040, 1, 0, 3'b010, 14'h100, 32'h0, 1, 0, 1, 0, 32'hDEADBEEF);
            else
                add(1, 14'h040, 1, 0, 3'b010, 14'h100, 32'h0, 0, 1, 1, 0, 32'h12345678);
        end

        // Reset held low with both requesters active
        drive_idle();
        bus.i_req  = 1'b1;
        bus.i_addr = 14'h040;
        bus.d_req  = 1'b1;
        bus.d_size = 3'b010;
        bus.d_addr = 14'h100;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_i_gnt", 32'(bus.i_gnt), 32'h0);
        check("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
        check("rst_m_en", 32'(bus.m_en), 32'h0);
        check("rst_i_rvalid", 32'(bus.i_rvalid), 32'h0);
        check("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        check("rst_d_err", 32'(bus.d_err), 32'h0);
        check("rst_i_rdata", bus.i_rdata, 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        reset = 1'b1;
        #1;
        check("post_rst_d_gnt", 32'(bus.d_gnt), 32'h1);
        check("post_rst_i_gnt", 32'(bus.i_gnt), 32'h0);
        sb.push_back('{1'b0, 1'b0, 32'h0});

        for (int k = 0; k < vt.size(); k++) begin
            @(posedge clk);
            #1;
            check_resp($sformatf("v%0d", k));
            drive(vt[k]);
            #1;
            check($sformatf("v%0d_i_gnt", k), 32'(bus.i_gnt), 32'(vt[k].e_i_gnt));
            check($sformatf("v%0d_d_gnt", k), 32'(bus.d_gnt), 32'(vt[k].e_d_gnt));
            check($sformatf("v%0d_m_en", k), 32'(bus.m_en), 32'(vt[k].e_m_en));
            if (vt[k].e_i_gnt)
                sb.push_back('{1'b1, 1'b0, vt[k].e_data});
            else if (vt[k].e_d_gnt)
                sb.push_back('{1'b0, vt[k].e_err, vt[k].e_data});
        end
        @(posedge clk);
        #1;
        check_resp("tail");
        drive_idle();
        check("sb_empty", 32'(sb.size()), 32'h0);

        // Reset pulsed while an I response is outstanding
        @(posedge clk);
        #1;
        bus.i_req  = 1'b1;
        bus.i_addr = 14'h040;
        #1;
        check("mid_i_gnt", 32'(bus.i_gnt), 32'h1);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        check("mid_i_rvalid", 32'(bus.i_rvalid), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_i_rvalid", 32'(bus.i_rvalid), 32'h0);
        check("mid_rst_i_rdata", bus.i_rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("after_rst%0d_i_rvalid", c), 32'(bus.i_rvalid), 32'h0);
            check($sformatf("after_rst%0d_d_rvalid", c), 32'(bus.d_rvalid), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
